// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with wrap-bit pointers, status flags, sticky error flags,
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] head;

  // Status is pure combinational decode of the registered pointers, so it never lags.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign head   = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !wr_acc) overflow <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid, and a
  // resettable array would prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : head;
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= head;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read instance and a FWFT instance
// share stimulus; each scenario task checks its own expected values.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] wr_data = '0;

  logic [15:0] d0_rd_data, d1_rd_data;
  logic        d0_rd_valid, d1_rd_valid;
  logic        d0_full, d1_full, d0_empty, d1_empty;
  logic        d0_af, d1_af, d0_ae, d1_ae;
  logic [4:0]  d0_count, d1_count;
  logic        d0_ovf, d1_ovf, d0_udf, d1_udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(16), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d0_rd_data), .rd_valid(d0_rd_valid), .full(d0_full), .empty(d0_empty),
    .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_udf));

  sync_fifo_param #(.WIDTH(16), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .full(d1_full), .empty(d1_empty),
    .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_udf));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hAAAA;
    tick(); tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (d0_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", d0_count); end
    checks++; if ({d0_empty, d0_full, d0_ae, d0_af} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b exp 1010", {d0_empty, d0_full, d0_ae, d0_af}); end
    checks++; if (d0_rd_data !== 16'h0 || d0_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd got %h/%b exp 0000/0", d0_rd_data, d0_rd_valid); end
    checks++; if ({d0_ovf, d0_udf} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {d0_ovf, d0_udf}); end
    checks++; if (d1_rd_data !== 16'h0 || d1_rd_valid !== 1'b0 || d1_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got %h/%b/%b exp 0000/0/1", d1_rd_data, d1_rd_valid, d1_empty); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'(i));
    checks++; if (d0_count !== 5'd5 || d0_ae !== 1'b0) begin errors++; $display("FAIL basic_fill got cnt %0d ae %b exp 5 0", d0_count, d0_ae); end
    for (int i = 1; i <= 5; i++) begin
      rd_en = 1'b1;
      tick();
      checks++; if (d0_rd_data !== 16'(i) || d0_rd_valid !== 1'b1) begin errors++; $display("FAIL basic_read%0d got %h/%b exp %h/1", i, d0_rd_data, d0_rd_valid, 16'(i)); end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (d0_rd_valid !== 1'b0 || d0_rd_data !== 16'h5) begin errors++; $display("FAIL basic_hold got %h/%b exp 0005/0", d0_rd_data, d0_rd_valid); end
    checks++; if (d0_empty !== 1'b1 || d0_count !== 5'd0) begin errors++; $display("FAIL basic_empty got %b/%0d exp 1/0", d0_empty, d0_count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(16'h0100 + 16'(i));
      checks++; if (d0_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count%0d got %0d exp %0d", i, d0_count, i + 1); end
      checks++; if (d0_af !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_af%0d got %b exp %b", i, d0_af, (i + 1 >= 14)); end
      checks++; if (d0_full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full%0d got %b exp %b", i, d0_full, (i + 1 == 16)); end
    end
    checks++; if (d0_ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", d0_ovf); end
    push(16'hDEAD);
    checks++; if (d0_ovf !== 1'b1 || d0_count !== 5'd16 || d0_full !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b/%0d/%b exp 1/16/1", d0_ovf, d0_count, d0_full); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (d0_rd_data !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL fill_read%0d got %h exp %h", i, d0_rd_data, 16'h0100 + 16'(i)); end
    end
    rd_en = 1'b0;
    checks++; if (d0_empty !== 1'b1 || d0_ovf !== 1'b1) begin errors++; $display("FAIL fill_end got %b/%b exp 1/1", d0_empty, d0_ovf); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 16; i++) push(16'h0200 + 16'(i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h02FF;
    tick();
    wr_en = 1'b0;
    checks++; if (d0_count !== 5'd16 || d0_full !== 1'b1) begin errors++; $display("FAIL fullrw_count got %0d/%b exp 16/1", d0_count, d0_full); end
    checks++; if (d0_rd_data !== 16'h0200 || d0_rd_valid !== 1'b1) begin errors++; $display("FAIL fullrw_oldest got %h/%b exp 0200/1", d0_rd_data, d0_rd_valid); end
    checks++; if (d0_ovf !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b exp 0", d0_ovf); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (d0_rd_data !== ((i == 16) ? 16'h02FF : 16'h0200 + 16'(i))) begin errors++; $display("FAIL fullrw_read%0d got %h exp %h", i, d0_rd_data, (i == 16) ? 16'h02FF : 16'h0200 + 16'(i)); end
    end
    rd_en = 1'b0;
    tick();
    checks++; if (d0_empty !== 1'b1 || d0_udf !== 1'b0) begin errors++; $display("FAIL fullrw_end got %b/%b exp 1/0", d0_empty, d0_udf); end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1;
    tick();
    checks++; if (d0_udf !== 1'b1 || d0_rd_valid !== 1'b0 || d0_count !== 5'd0 || d0_rd_data !== 16'h0) begin errors++; $display("FAIL udf_alone got %b/%b/%0d/%h exp 1/0/0/0000", d0_udf, d0_rd_valid, d0_count, d0_rd_data); end
    wr_en = 1'b1; wr_data = 16'h0055;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (d0_count !== 5'd1 || d0_empty !== 1'b0 || d0_udf !== 1'b1 || d0_rd_valid !== 1'b0) begin errors++; $display("FAIL udf_rw got %0d/%b/%b/%b exp 1/0/1/0", d0_count, d0_empty, d0_udf, d0_rd_valid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (d0_rd_data !== 16'h0055 || d0_rd_valid !== 1'b1) begin errors++; $display("FAIL udf_read got %h/%b exp 0055/1", d0_rd_data, d0_rd_valid); end
  endtask

  task automatic test_fwft_wrap();
    logic [15:0] q[$];
    int          pushed;
    do_reset();
    pushed = 0;
    for (int c = 0; c < 70; c++) begin
      wr_en   = (pushed < 40);
      wr_data = 16'h0300 + 16'(pushed);
      rd_en   = (c >= 3) && (c % 5 != 0) && (q.size() > 0);
      #1;
      checks++;
      if (q.size() > 0) begin
        if (d1_rd_data !== q[0] || d1_rd_valid !== 1'b1) begin errors++; $display("FAIL fwft_head%0d got %h/%b exp %h/1", c, d1_rd_data, d1_rd_valid, q[0]); end
      end else begin
        if (d1_rd_data !== 16'h0 || d1_rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_empty%0d got %h/%b exp 0000/0", c, d1_rd_data, d1_rd_valid); end
      end
      checks++; if (d1_count !== 5'(q.size())) begin errors++; $display("FAIL fwft_count%0d got %0d exp %0d", c, d1_count, q.size()); end
      if (rd_en) void'(q.pop_front());
      if (wr_en) begin q.push_back(wr_data); pushed++; end
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (d1_empty !== 1'b1 || d1_udf !== 1'b0 || d1_ovf !== 1'b0) begin errors++; $display("FAIL fwft_end got %b/%b/%b exp 1/0/0", d1_empty, d1_udf, d1_ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) push(16'h0400 + 16'(i));
    checks++; if (d0_count !== 5'd7) begin errors++; $display("FAIL midrst_pre got %0d exp 7", d0_count); end
    rst = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    checks++; if (d0_count !== 5'd0 || d0_empty !== 1'b1 || d0_full !== 1'b0 || d0_af !== 1'b0 || d0_ae !== 1'b1) begin errors++; $display("FAIL midrst_state got %0d/%b/%b/%b/%b exp 0/1/0/0/1", d0_count, d0_empty, d0_full, d0_af, d0_ae); end
    checks++; if (d0_ovf !== 1'b0 || d0_udf !== 1'b0 || d0_rd_valid !== 1'b0 || d0_rd_data !== 16'h0) begin errors++; $display("FAIL midrst_out got %b/%b/%b/%h exp 0/0/0/0000", d0_ovf, d0_udf, d0_rd_valid, d0_rd_data); end
    push(16'h0077);
    checks++; if (d0_count !== 5'd1) begin errors++; $display("FAIL midrst_first_wr got %0d exp 1", d0_count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (d0_rd_data !== 16'h0077) begin errors++; $display("FAIL midrst_read got %h exp 0077", d0_rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_underflow();
    test_fwft_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request (pop).
REQ-011 rd_data  output  WIDTH  read data.
REQ-012 rd_valid  output  1  rd_data qualifier.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 almost_empty  output  1  count <= AE_LEVEL.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 overflow  output  1  sticky: write attempted and rejected.
REQ-019 underflow  output  1  sticky: read attempted while empty.

Function
REQ-020 Write and read pointers SHALL be $clog2(DEPTH)+1 bits; low bits address storage, MSB is wrap bit; pointers wrap modulo 2*DEPTH.
REQ-021 count SHALL equal wr_ptr - rd_ptr (modulo 2*DEPTH); full = MSBs differ and low bits equal; empty = pointers equal.
REQ-022 All status outputs SHALL be derived from registered pointers, reflecting state after the most recent edge; no extra lag.
REQ-023 Read accepted (rd_acc) iff rd_en && !empty.
REQ-024 Write accepted (wr_acc) iff wr_en && (!full || rd_acc); full FIFO with simultaneous read SHALL accept both, count unchanged.
REQ-025 Empty FIFO with simultaneous rd_en and wr_en: write accepted, read rejected, underflow set, count becomes 1.
REQ-026 wr_acc: storage[wr_ptr low bits] <= wr_data, wr_ptr += 1; rd_acc: rd_ptr += 1.
REQ-027 Simultaneous wr_acc and rd_acc SHALL leave count unchanged; count SHALL never exceed DEPTH nor go below 0.
REQ-028 FWFT=0: on rd_acc, rd_data <= head entry at the same edge (1-cycle latency); rd_valid = 1 the cycle after rd_acc, else 0; rd_data holds last value otherwise.
REQ-029 FWFT=1: rd_data = head entry combinationally whenever !empty, 0 when empty; rd_valid = !empty; rd_en pops the shown word.
REQ-030 overflow set on wr_en && !wr_acc; underflow set on rd_en && empty; both remain 1 until reset.
REQ-031 Rejected operations SHALL not modify storage, pointers or rd_data.
REQ-032 Data SHALL be returned in write order with no loss or duplication across pointer wrap.

Reset
REQ-033 On rst at a rising edge: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0.
REQ-034 rst SHALL take priority over concurrent wr_en/rd_en; mid-operation reset discards contents; storage itself not cleared.
REQ-035 First write after reset release SHALL be accepted on the first edge with rst low.

Verification (DEPTH=16, WIDTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-036 FWFT=0: write 0x0001..0x0005, then 5 reads -> rd_data 1..5 each one cycle after its rd_en with rd_valid=1; empty=1, count=0 afterwards.
REQ-037 Fill with 16 writes -> full=1 at count 16, almost_full from count 14; 17th write rejected, overflow=1, contents intact on readback.
REQ-038 Full FIFO, wr_en and rd_en same cycle -> both accepted, count stays 16, oldest word out, new word read last.
REQ-039 Empty FIFO, rd_en alone -> underflow=1, rd_valid=0; rd_en+wr_en together -> count=1, underflow stays 1.
REQ-040 40 writes/reads interleaved (pointer wrap twice) with FWFT=1 -> rd_data matches head while !empty, ordering preserved.
REQ-041 Assert rst with count=7 and wr_en high -> next cycle count=0, empty=1, flags 0, no write recorded.
